// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a bounded memory handshake and a sticky TRAP.
// Optional retired-instruction counter enabled by defining MULTICYCLE_CONTROL_INSTRET_EN.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] instruction_opcode,
    input  logic       mem_ack,
    output logic       instr_fetch,
    output logic       memory_read,
    output logic       memory_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic [1:0] memory_to_reg,
    output logic       reg_write,
    output logic       trap,
    output logic [2:0] state
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    ,
    output logic [COUNTER_WIDTH-1:0] instret
`endif
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'b000,
        S_DECODE    = 3'b001,
        S_EXECUTE   = 3'b010,
        S_MEMORY    = 3'b011,
        S_WRITEBACK = 3'b100,
        S_TRAP      = 3'b111
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam int CNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             opcode_legal;
    logic             is_load;
    logic             is_store;
    logic             is_ctrl_xfer;

    assign is_load      = (instruction_opcode == OP_LOAD);
    assign is_store     = (instruction_opcode == OP_STORE);
    assign is_ctrl_xfer = (instruction_opcode == OP_BR) || (instruction_opcode == OP_JAL) ||
                          (instruction_opcode == OP_JALR);
    assign opcode_legal = is_load || is_store || is_ctrl_xfer ||
                          (instruction_opcode == OP_R) || (instruction_opcode == OP_I) ||
                          (instruction_opcode == OP_LUI) || (instruction_opcode == OP_AUIPC);
    assign state = state_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                // FETCH and MEMORY share the wait counter; an ack on the last allowed cycle still wins.
                S_FETCH: begin
                    if (mem_ack) begin
                        state_reg    <= S_DECODE;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == CNT_LAST) begin
                        state_reg    <= S_TRAP;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_DECODE: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= opcode_legal ? S_EXECUTE : S_TRAP;
                end
                S_EXECUTE: begin
                    if (is_load || is_store)
                        state_reg <= S_MEMORY;
                    else if (is_ctrl_xfer)
                        state_reg <= S_FETCH;
                    else if (opcode_legal)
                        state_reg <= S_WRITEBACK;
                    else
                        state_reg <= S_TRAP;
                end
                S_MEMORY: begin
                    if (!(is_load || is_store)) begin
                        state_reg <= S_TRAP;
                    end else if (mem_ack) begin
                        state_reg    <= is_load ? S_WRITEBACK : S_FETCH;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == CNT_LAST) begin
                        state_reg    <= S_TRAP;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                S_WRITEBACK: state_reg <= S_FETCH;
                S_TRAP:      state_reg <= S_TRAP;
                default:     state_reg <= S_TRAP;
            endcase
        end
    end

    // Control strobes are decoded from the current state; FETCH adds the Mealy ack terms.
    always_comb begin
        instr_fetch   = 1'b0;
        memory_read   = 1'b0;
        memory_write  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        branch        = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        aluop         = 2'b00;
        memory_to_reg = 2'b00;
        reg_write     = 1'b0;
        trap          = 1'b0;
        if (reset) begin
            alu_src_b = 2'b10;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    instr_fetch = 1'b1;
                    memory_read = 1'b1;
                    alu_src_a   = 2'b01;
                    alu_src_b   = 2'b10;
                    ir_write    = mem_ack;
                    pc_write    = mem_ack;
                end
                S_EXECUTE: begin
                    case (instruction_opcode)
                        OP_LOAD, OP_STORE: alu_src_b = 2'b01;
                        OP_R:              aluop = 2'b10;
                        OP_I: begin
                            alu_src_b = 2'b01;
                            aluop     = 2'b11;
                        end
                        OP_LUI: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b01;
                        end
                        OP_AUIPC: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b01;
                        end
                        OP_BR: begin
                            aluop     = 2'b01;
                            branch    = 1'b1;
                            pc_source = 1'b1;
                        end
                        OP_JAL, OP_JALR: begin
                            alu_src_a     = (instruction_opcode == OP_JAL) ? 2'b01 : 2'b00;
                            alu_src_b     = 2'b01;
                            pc_write      = 1'b1;
                            pc_source     = 1'b1;
                            reg_write     = 1'b1;
                            memory_to_reg = 2'b10;
                        end
                        default: ;
                    endcase
                end
                S_MEMORY: begin
                    memory_read  = is_load;
                    memory_write = is_store;
                end
                S_WRITEBACK: begin
                    reg_write     = 1'b1;
                    memory_to_reg = is_load ? 2'b01 : 2'b00;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    logic retire;

    assign retire = (state_reg == S_WRITEBACK) ||
                    ((state_reg == S_EXECUTE) && is_ctrl_xfer) ||
                    ((state_reg == S_MEMORY) && is_store && mem_ack);

    always_ff @(posedge clk) begin
        if (reset)
            instret <= '0;
        else if (retire)
            instret <= instret + 1'b1;
    end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit (MEM_TIMEOUT = 4), one line per checked cycle on failure.
module tb_multicycle_control_unit;

    localparam int MEM_TIMEOUT = 4;
    localparam int CW          = 32;
    localparam int unsigned NA = 32'hFFFF_FFFF;

    localparam logic [6:0] R   = 7'b0110011, I   = 7'b0010011, LD  = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011, JAL = 7'b1101111, JR  = 7'b1100111;
    localparam logic [6:0] LUI = 7'b0110111, AUI = 7'b0010111, ILL = 7'b1111111;

    // Expected control bundle: {instr_fetch, memory_read, memory_write, ir_write, pc_write, branch,
    // pc_source, alu_src_a, alu_src_b, aluop, memory_to_reg, reg_write, trap}
    localparam logic [16:0] C_RST   = {7'b0000000, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_FW    = {7'b1100000, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_FA    = {7'b1101100, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_DEC   = 17'd0;
    localparam logic [16:0] C_EXR   = {7'b0000000, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_EXI   = {7'b0000000, 2'b00, 2'b01, 2'b11, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_EXLS  = {7'b0000000, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_EXLUI = {7'b0000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_EXAUI = {7'b0000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_EXBR  = {7'b0000011, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_EXJAL = {7'b0000101, 2'b01, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [16:0] C_EXJR  = {7'b0000101, 2'b00, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0};
    localparam logic [16:0] C_MLD   = {7'b0100000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_MST   = {7'b0010000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    localparam logic [16:0] C_WBA   = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    localparam logic [16:0] C_WBL   = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
    localparam logic [16:0] C_TRAP  = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        ack;
        logic [2:0]  st;
        logic [16:0] ctl;
        int unsigned ir;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] instruction_opcode;
    logic mem_ack;
    logic instr_fetch, memory_read, memory_write, ir_write, pc_write, branch, pc_source;
    logic [1:0] alu_src_a, alu_src_b, aluop, memory_to_reg;
    logic reg_write, trap;
    logic [2:0] state;
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
    logic [CW-1:0] instret;
`endif

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .instruction_opcode(instruction_opcode), .mem_ack(mem_ack),
        .instr_fetch(instr_fetch), .memory_read(memory_read), .memory_write(memory_write),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .memory_to_reg(memory_to_reg),
        .reg_write(reg_write), .trap(trap), .state(state)
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
        , .instret(instret)
`endif
    );

    function automatic vec_t v(input logic rst, input logic [6:0] op, input logic ack,
                               input logic [2:0] st, input logic [16:0] ctl, input int unsigned ir);
        vec_t r;
        r.rst = rst; r.op = op; r.ack = ack; r.st = st; r.ctl = ctl; r.ir = ir;
        return r;
    endfunction

    // Drive inputs on the falling edge, check state and (Mealy) outputs 1 ns later.
    task automatic step(input vec_t t, input string tag);
        logic [16:0] act;
        @(negedge clk);
        reset = t.rst; instruction_opcode = t.op; mem_ack = t.ack;
        #1;
        act = {instr_fetch, memory_read, memory_write, ir_write, pc_write, branch, pc_source,
               alu_src_a, alu_src_b, aluop, memory_to_reg, reg_write, trap};
        checks++;
        if (state !== t.st) begin
            failures++;
            $display("FAIL %s state: got %03b want %03b", tag, state, t.st);
        end
        checks++;
        if (act !== t.ctl) begin
            failures++;
            $display("FAIL %s ctl: got %017b want %017b", tag, act, t.ctl);
        end
`ifdef MULTICYCLE_CONTROL_INSTRET_EN
        if (t.ir != NA) begin
            checks++;
            if (instret !== CW'(t.ir)) begin
                failures++;
                $display("FAIL %s instret: got %0d want %0d", tag, instret, t.ir);
            end
        end
`endif
    endtask

    initial begin
        reset = 1'b1; instruction_opcode = 7'd0; mem_ack = 1'b0;
        @(posedge clk);

        // R-type, zero-wait
        vecs.push_back(v(1, R, 1, 3'd0, C_RST, 0));
        vecs.push_back(v(1, R, 1, 3'd0, C_RST, 0));
        vecs.push_back(v(0, R, 1, 3'd0, C_FA,  0));
        vecs.push_back(v(0, R, 1, 3'd1, C_DEC, 0));
        vecs.push_back(v(0, R, 1, 3'd2, C_EXR, 0));
        vecs.push_back(v(0, R, 1, 3'd4, C_WBA, 0));
        // LOAD with three wait cycles in MEMORY (ack on the last allowed cycle)
        vecs.push_back(v(0, LD, 1, 3'd0, C_FA,   1));
        vecs.push_back(v(0, LD, 0, 3'd1, C_DEC,  1));
        vecs.push_back(v(0, LD, 0, 3'd2, C_EXLS, 1));
        vecs.push_back(v(0, LD, 0, 3'd3, C_MLD,  1));
        vecs.push_back(v(0, LD, 0, 3'd3, C_MLD,  1));
        vecs.push_back(v(0, LD, 0, 3'd3, C_MLD,  1));
        vecs.push_back(v(0, LD, 1, 3'd3, C_MLD,  1));
        vecs.push_back(v(0, LD, 0, 3'd4, C_WBL,  1));
        // STORE with one fetch wait; ack in DECODE/EXECUTE is ignored
        vecs.push_back(v(0, ST, 0, 3'd0, C_FW,   2));
        vecs.push_back(v(0, ST, 1, 3'd0, C_FA,   2));
        vecs.push_back(v(0, ST, 1, 3'd1, C_DEC,  2));
        vecs.push_back(v(0, ST, 1, 3'd2, C_EXLS, 2));
        vecs.push_back(v(0, ST, 0, 3'd3, C_MST,  2));
        vecs.push_back(v(0, ST, 1, 3'd3, C_MST,  2));
        // JAL
        vecs.push_back(v(0, JAL, 1, 3'd0, C_FA,    3));
        vecs.push_back(v(0, JAL, 1, 3'd1, C_DEC,   3));
        vecs.push_back(v(0, JAL, 1, 3'd2, C_EXJAL, 3));
        // I-ALU, LUI, AUIPC
        vecs.push_back(v(0, I, 1, 3'd0, C_FA,  4));
        vecs.push_back(v(0, I, 1, 3'd1, C_DEC, 4));
        vecs.push_back(v(0, I, 1, 3'd2, C_EXI, 4));
        vecs.push_back(v(0, I, 1, 3'd4, C_WBA, 4));
        vecs.push_back(v(0, LUI, 1, 3'd0, C_FA,    5));
        vecs.push_back(v(0, LUI, 1, 3'd1, C_DEC,   5));
        vecs.push_back(v(0, LUI, 1, 3'd2, C_EXLUI, 5));
        vecs.push_back(v(0, LUI, 1, 3'd4, C_WBA,   5));
        vecs.push_back(v(0, AUI, 1, 3'd0, C_FA,    6));
        vecs.push_back(v(0, AUI, 1, 3'd1, C_DEC,   6));
        vecs.push_back(v(0, AUI, 1, 3'd2, C_EXAUI, 6));
        vecs.push_back(v(0, AUI, 1, 3'd4, C_WBA,   6));
        // BRANCH, JALR
        vecs.push_back(v(0, BR, 1, 3'd0, C_FA,   7));
        vecs.push_back(v(0, BR, 1, 3'd1, C_DEC,  7));
        vecs.push_back(v(0, BR, 1, 3'd2, C_EXBR, 7));
        vecs.push_back(v(0, JR, 1, 3'd0, C_FA,   8));
        vecs.push_back(v(0, JR, 1, 3'd1, C_DEC,  8));
        vecs.push_back(v(0, JR, 1, 3'd2, C_EXJR, 8));
        // Illegal opcode
        vecs.push_back(v(0, ILL, 1, 3'd0, C_FA,   9));
        vecs.push_back(v(0, ILL, 1, 3'd1, C_DEC,  9));
        vecs.push_back(v(0, ILL, 1, 3'd7, C_TRAP, 9));

        foreach (vecs[k]) step(vecs[k], $sformatf("row%0d", k));

        // Trap is sticky for 20 cycles regardless of ack, then reset clears it
        for (int k = 0; k < 20; k++)
            step(v(0, (k % 2 == 0) ? ILL : R, k[0], 3'd7, C_TRAP, 9), $sformatf("trap_hold%0d", k));
        step(v(1, R, 1, 3'd7, C_RST, 9), "trap_reset");

        // Fetch timeout: four ack-less FETCH cycles then TRAP
        for (int k = 0; k < 4; k++)
            step(v(0, R, 0, 3'd0, C_FW, 0), $sformatf("fto_wait%0d", k));
        step(v(0, R, 0, 3'd7, C_TRAP, 0), "fto_trap");
        step(v(1, R, 0, 3'd7, C_RST, 0), "fto_reset");

        // Ack on the fourth FETCH cycle wins over the timeout
        for (int k = 0; k < 3; k++)
            step(v(0, R, 0, 3'd0, C_FW, 0), $sformatf("fack_wait%0d", k));
        step(v(0, R, 1, 3'd0, C_FA,  0), "fack_last");
        step(v(0, R, 0, 3'd1, C_DEC, 0), "fack_dec");
        step(v(0, R, 0, 3'd2, C_EXR, 0), "fack_ex");
        step(v(0, R, 0, 3'd4, C_WBA, 0), "fack_wb");

        // Reset mid-STORE in MEMORY with ack high: no write strobe, back to FETCH
        step(v(0, ST, 1, 3'd0, C_FA,   1), "mrst_fetch");
        step(v(0, ST, 0, 3'd1, C_DEC,  1), "mrst_dec");
        step(v(0, ST, 0, 3'd2, C_EXLS, 1), "mrst_ex");
        step(v(0, ST, 0, 3'd3, C_MST,  1), "mrst_mem");
        step(v(1, ST, 1, 3'd3, C_RST,  1), "mrst_reset");
        step(v(0, LD, 1, 3'd0, C_FA,   0), "mrst_after");

        // Memory timeout on a LOAD
        step(v(0, LD, 0, 3'd1, C_DEC,  0), "mto_dec");
        step(v(0, LD, 0, 3'd2, C_EXLS, 0), "mto_ex");
        for (int k = 0; k < 4; k++)
            step(v(0, LD, 0, 3'd3, C_MLD, 0), $sformatf("mto_wait%0d", k));
        step(v(0, LD, 1, 3'd7, C_TRAP, 0), "mto_trap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
